perf_count_ctrl: RTL and testbench
==================================

Name: perf_count_ctrl

Overview:
- Controller for the three 20-bit performance counter registers: instruction count, memory access and memory correction.
- Gates event pulses into the per-counter inc strobes.
- Serves single-counter read requests through a snapshot and a valid/ready handshake, with optional clear-on-read.
- Issues per-counter and global clears, and tracks sticky wrap (overflow) flags.
- Sits between the core/memory event sources and the counter registers; a debug/CSR reader is the requester.

Parameters:
- CNT_W, 20, counter width; must match the counter registers.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global count enable
- inst_evt  in  1  instruction-retired event, one per cycle max
- ma_evt  in  1  memory-access event
- mc_evt  in  1  memory-correction event
- ic_count  in  CNT_W  current instruction counter value
- ma_count  in  CNT_W  current memory access counter value
- mc_count  in  CNT_W  current memory correction counter value
- ic_inc  out  1  increment strobe to instruction counter
- ma_inc  out  1  increment strobe to memory access counter
- mc_inc  out  1  increment strobe to memory correction counter
- cnt_clr  out  3  registered per-counter clear; bit0=ic, bit1=ma, bit2=mc
- clr_all  in  1  request to clear all counters
- rd_req  in  1  read request, level, held until rd_valid
- rd_sel  in  2  counter select: 0=ic, 1=ma, 2=mc, 3=invalid
- rd_clr  in  1  clear selected counter after the read completes
- rd_valid  out  1  read data valid
- rd_ready  in  1  requester accepts data
- rd_data  out  CNT_W  snapshot value
- rd_ovf  out  1  overflow flag of selected counter at snapshot
- rd_err  out  1  one-cycle pulse when rd_sel=3 is requested
- ovf  out  3  sticky wrap flags, same bit order as cnt_clr
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (rst sampled high on a clk edge): state IDLE; rd_valid, rd_data, rd_ovf, rd_err, ovf, cnt_clr and busy all 0. Reset aborts any state, including mid-handshake.
- Inc strobes are combinational: x_inc = x_evt & en & ~(state==CLEAR & selected/all-cleared counter x).
  - During a clear, an event on the cleared counter is dropped; other counters keep counting.
- Overflow: ovf[i] sets on an edge where x_inc=1 and the count is all ones; the counter register wraps to 0.
  - ovf[i] is cleared only by rst or by a clear of counter i. Clear wins over a simultaneous set.
- FSM states: IDLE, SNAP, PRESENT, CLEAR.
  - IDLE + clr_all=1: go to CLEAR with all three targeted. clr_all has priority over rd_req; rd_req is not accepted that cycle.
  - IDLE + rd_req=1 + rd_sel<3: latch sel and rd_clr, go to SNAP.
  - IDLE + rd_req=1 + rd_sel=3: pulse rd_err for one cycle, stay in IDLE. Requester must drop rd_req.
  - SNAP: on the edge, rd_data <= count[sel] and rd_ovf <= ovf[sel]. The captured value is the pre-edge value, so an increment strobed in the SNAP cycle is excluded. Set rd_valid and go to PRESENT.
  - PRESENT: rd_valid, rd_data and rd_ovf are held stable until rd_valid & rd_ready. On handshake, rd_valid <= 0, then go to CLEAR with sel targeted if the latched rd_clr=1, else go to IDLE.
  - CLEAR: cnt_clr is high for exactly this one cycle on the targeted bits (registered, glitch-free; it drives the counter register reset). ovf bits for the targeted counters are cleared. Return to IDLE.
- Latency:
  - rd_req sampled in IDLE at edge N gives rd_valid high after edge N+1.
  - The minimum request-to-IDLE turnaround is 3 cycles without clear and 4 with clear.
- rd_ready is ignored outside PRESENT. clr_all outside IDLE is ignored; the requester must hold it until busy=0.
- en=0 suppresses all inc strobes but does not block reads or clears.

Test Plan:
- rst, then en=1 and 5 inst_evt pulses; counters stubbed with real registers -> ic_count=5, ma=0, mc=0, ovf=0, busy=0.
- Read ic with rd_ready tied 1: rd_req@N, rd_sel=0, rd_clr=0 -> rd_valid@N+2 with rd_data=5, one-cycle valid, ic_count stays 5.
- Read ma with rd_clr=1 while ma_evt is continuous -> rd_data equals the count before the SNAP edge. Hold rd_ready=0 for 4 cycles -> data stable. After handshake, cnt_clr=3'b010 for one cycle -> ma_count restarts from 0.
- Preload mc=20'hFFFFF, one mc_evt -> mc_count=0, ovf=3'b100. Read mc -> rd_ovf=1. Read again with rd_clr -> ovf=3'b000.
- clr_all and rd_req in the same IDLE cycle -> cnt_clr=3'b111 for one cycle; the read is accepted on the next IDLE cycle. rd_sel=3 -> rd_err single pulse, busy stays 0.
- rst asserted in PRESENT -> next cycle IDLE, rd_valid=0, rd_data=0, ovf=0, no cnt_clr pulse.

Source files
------------

// File: rtl/perf_count_ctrl.sv
// Performance counter controller: gates event strobes, serves snapshot reads
// over a valid/ready handshake, issues clears and tracks sticky wrap flags.
module perf_count_ctrl #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             inst_evt,
   input  logic             ma_evt,
   input  logic             mc_evt,
   input  logic [CNT_W-1:0] ic_count,
   input  logic [CNT_W-1:0] ma_count,
   input  logic [CNT_W-1:0] mc_count,
   output logic             ic_inc,
   output logic             ma_inc,
   output logic             mc_inc,
   output logic [2:0]       cnt_clr,
   input  logic             clr_all,
   input  logic             rd_req,
   input  logic [1:0]       rd_sel,
   input  logic             rd_clr,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_ovf,
   output logic             rd_err,
   output logic [2:0]       ovf,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SNAP,
      ST_PRESENT,
      ST_CLEAR
   } state_e;

   state_e           state_q,     state_d;
   logic [1:0]       sel_q,       sel_d;
   logic             clr_on_rd_q, clr_on_rd_d;
   logic [2:0]       cnt_clr_q,   cnt_clr_d;
   logic             rd_valid_q,  rd_valid_d;
   logic [CNT_W-1:0] rd_data_q,   rd_data_d;
   logic             rd_ovf_q,    rd_ovf_d;
   logic             rd_err_q,    rd_err_d;
   logic [2:0]       ovf_q,       ovf_d;

   logic [2:0]       evt_vec;
   logic [2:0]       inc_vec;
   logic [2:0]       wrap_vec;
   logic [2:0]       clr_active;
   logic [2:0]       sel_mask;
   logic [CNT_W-1:0] sel_count;
   logic             sel_ovf;

   // Counters being cleared this cycle must not also be incremented.
   assign clr_active = (state_q == ST_CLEAR) ? cnt_clr_q : 3'b000;
   assign evt_vec    = {mc_evt, ma_evt, inst_evt};
   assign inc_vec    = evt_vec & {3{en}} & ~clr_active;
   assign wrap_vec   = {&mc_count, &ma_count, &ic_count};
   assign sel_mask   = 3'b001 << sel_q;

   // Clear beats a wrap landing on the same edge.
   assign ovf_d = (ovf_q | (inc_vec & wrap_vec)) & ~clr_active;

   always_comb begin
      sel_count = '0;
      sel_ovf   = 1'b0;
      case (sel_q)
         2'd0: begin
            sel_count = ic_count;
            sel_ovf   = ovf_q[0];
         end
         2'd1: begin
            sel_count = ma_count;
            sel_ovf   = ovf_q[1];
         end
         2'd2: begin
            sel_count = mc_count;
            sel_ovf   = ovf_q[2];
         end
         default: begin
            sel_count = '0;
            sel_ovf   = 1'b0;
         end
      endcase
   end

   // NOTE: every output of this block gets a default first so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      clr_on_rd_d = clr_on_rd_q;
      cnt_clr_d   = 3'b000;
      rd_valid_d  = rd_valid_q;
      rd_data_d   = rd_data_q;
      rd_ovf_d    = rd_ovf_q;
      rd_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (clr_all) begin
               state_d   = ST_CLEAR;
               cnt_clr_d = 3'b111;
            end else if (rd_req) begin
               if (rd_sel == 2'd3) begin
                  rd_err_d = 1'b1;
               end else begin
                  sel_d       = rd_sel;
                  clr_on_rd_d = rd_clr;
                  state_d     = ST_SNAP;
               end
            end
         end

         ST_SNAP: begin
            rd_data_d  = sel_count;
            rd_ovf_d   = sel_ovf;
            rd_valid_d = 1'b1;
            state_d    = ST_PRESENT;
         end

         ST_PRESENT: begin
            if (rd_ready) begin
               rd_valid_d = 1'b0;
               if (clr_on_rd_q) begin
                  state_d   = ST_CLEAR;
                  cnt_clr_d = sel_mask;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_CLEAR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= 2'd0;
         clr_on_rd_q <= 1'b0;
         cnt_clr_q   <= 3'b000;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_ovf_q    <= 1'b0;
         rd_err_q    <= 1'b0;
         ovf_q       <= 3'b000;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         clr_on_rd_q <= clr_on_rd_d;
         cnt_clr_q   <= cnt_clr_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         rd_ovf_q    <= rd_ovf_d;
         rd_err_q    <= rd_err_d;
         ovf_q       <= ovf_d;
      end
   end

   assign ic_inc   = inc_vec[0];
   assign ma_inc   = inc_vec[1];
   assign mc_inc   = inc_vec[2];
   assign cnt_clr  = cnt_clr_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_ovf   = rd_ovf_q;
   assign rd_err   = rd_err_q;
   assign ovf      = ovf_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_perf_count_ctrl.sv
// Directed bench for perf_count_ctrl with real counter registers around it
// and a scoreboard of expected read results.
module tb_perf_count_ctrl;

   localparam int CNT_W = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             inst_evt, ma_evt, mc_evt;
   logic [CNT_W-1:0] ic_count, ma_count, mc_count;
   logic             ic_inc, ma_inc, mc_inc;
   logic [2:0]       cnt_clr;
   logic             clr_all;
   logic             rd_req;
   logic [1:0]       rd_sel;
   logic             rd_clr;
   logic             rd_valid;
   logic             rd_ready;
   logic [CNT_W-1:0] rd_data;
   logic             rd_ovf;
   logic             rd_err;
   logic [2:0]       ovf;
   logic             busy;

   logic             mc_load;
   logic [CNT_W-1:0] mc_load_val;

   typedef struct packed {
      logic [CNT_W-1:0] data;
      logic             ovf;
   } rd_exp_t;

   rd_exp_t exp_q[$];
   rd_exp_t sb_e;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   perf_count_ctrl #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .inst_evt (inst_evt),
      .ma_evt   (ma_evt),
      .mc_evt   (mc_evt),
      .ic_count (ic_count),
      .ma_count (ma_count),
      .mc_count (mc_count),
      .ic_inc   (ic_inc),
      .ma_inc   (ma_inc),
      .mc_inc   (mc_inc),
      .cnt_clr  (cnt_clr),
      .clr_all  (clr_all),
      .rd_req   (rd_req),
      .rd_sel   (rd_sel),
      .rd_clr   (rd_clr),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_ovf   (rd_ovf),
      .rd_err   (rd_err),
      .ovf      (ovf),
      .busy     (busy)
   );

   // Counter registers driven by the controller's strobes and clears.
   always @(posedge clk) begin
      if (rst) begin
         ic_count <= '0;
         ma_count <= '0;
         mc_count <= '0;
      end else begin
         if (cnt_clr[0])  ic_count <= '0;
         else if (ic_inc) ic_count <= ic_count + 1'b1;
         if (cnt_clr[1])  ma_count <= '0;
         else if (ma_inc) ma_count <= ma_count + 1'b1;
         if (mc_load)     mc_count <= mc_load_val;
         else if (cnt_clr[2]) mc_count <= '0;
         else if (mc_inc) mc_count <= mc_count + 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: compare each accepted read against the queued expectation.
   always @(negedge clk) begin
      if (!rst && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=unexpected read data %0h expected=no read", rd_data);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_data", 32'(rd_data), 32'(sb_e.data));
            check("sb_ovf", 32'(rd_ovf), 32'(sb_e.ovf));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; en = 1'b0; inst_evt = 1'b0; ma_evt = 1'b0; mc_evt = 1'b0;
      clr_all = 1'b0; rd_req = 1'b0; rd_sel = 2'd0; rd_clr = 1'b0; rd_ready = 1'b0;
      mc_load = 1'b0; mc_load_val = '0;

      // Reset state
      tick(); tick();
      check("rst_valid", 32'(rd_valid), 0);
      check("rst_data", 32'(rd_data), 0);
      check("rst_ovf_rd", 32'(rd_ovf), 0);
      check("rst_err", 32'(rd_err), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_clr", 32'(cnt_clr), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;

      // en=0 blocks strobes, then five instruction events
      inst_evt = 1'b1;
      #1 check("en0_inc", 32'(ic_inc), 0);
      tick();
      check("en0_cnt", 32'(ic_count), 0);
      en = 1'b1;
      #1 check("en1_inc", 32'(ic_inc), 1);
      repeat (5) tick();
      inst_evt = 1'b0;
      check("ic5", 32'(ic_count), 5);
      check("ma0", 32'(ma_count), 0);
      check("mc0", 32'(mc_count), 0);
      check("ovf0", 32'(ovf), 0);
      check("idle0", 32'(busy), 0);

      // Read ic, rd_ready tied high
      exp_q.push_back({20'd5, 1'b0});
      rd_req = 1'b1; rd_sel = 2'd0; rd_clr = 1'b0; rd_ready = 1'b1;
      tick();
      check("ic_snap_busy", 32'(busy), 1);
      check("ic_snap_valid", 32'(rd_valid), 0);
      tick();
      check("ic_valid", 32'(rd_valid), 1);
      check("ic_data", 32'(rd_data), 5);
      rd_req = 1'b0;
      tick();
      check("ic_valid_drop", 32'(rd_valid), 0);
      check("ic_idle", 32'(busy), 0);
      check("ic_kept", 32'(ic_count), 5);

      // Read ma with clear while ma events stream, requester stalls
      ma_evt = 1'b1;
      repeat (3) tick();
      exp_q.push_back({20'd4, 1'b0});
      rd_req = 1'b1; rd_sel = 2'd1; rd_clr = 1'b1; rd_ready = 1'b0;
      tick();
      tick();
      check("ma_valid", 32'(rd_valid), 1);
      check("ma_data", 32'(rd_data), 4);
      rd_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ma_hold_valid", 32'(rd_valid), 1);
         check("ma_hold_data", 32'(rd_data), 4);
      end
      rd_ready = 1'b1;
      tick();
      check("ma_clr_pulse", 32'(cnt_clr), 3'b010);
      check("ma_clr_busy", 32'(busy), 1);
      check("ma_clr_valid", 32'(rd_valid), 0);
      check("ma_inc_gated", 32'(ma_inc), 0);
      check("ic_inc_free", 32'(ic_inc), 0);
      tick();
      check("ma_clr_done", 32'(cnt_clr), 0);
      check("ma_clr_idle", 32'(busy), 0);
      check("ma_cleared", 32'(ma_count), 0);
      tick();
      check("ma_restart", 32'(ma_count), 1);
      ma_evt = 1'b0;

      // mc wrap sets sticky overflow
      mc_load = 1'b1; mc_load_val = 20'hFFFFF;
      tick();
      mc_load = 1'b0;
      check("mc_preload", 32'(mc_count), 32'h000FFFFF);
      mc_evt = 1'b1;
      #1 check("mc_inc", 32'(mc_inc), 1);
      tick();
      mc_evt = 1'b0;
      check("mc_wrap", 32'(mc_count), 0);
      check("mc_ovf_set", 32'(ovf), 3'b100);

      // Read mc without clear
      exp_q.push_back({20'd0, 1'b1});
      rd_req = 1'b1; rd_sel = 2'd2; rd_clr = 1'b0;
      tick(); tick();
      check("mc_valid", 32'(rd_valid), 1);
      check("mc_rd_ovf", 32'(rd_ovf), 1);
      rd_req = 1'b0;
      tick();
      check("mc_idle", 32'(busy), 0);
      check("mc_ovf_kept", 32'(ovf), 3'b100);

      // Read mc with clear: overflow flag cleared by the clear cycle
      exp_q.push_back({20'd0, 1'b1});
      rd_req = 1'b1; rd_sel = 2'd2; rd_clr = 1'b1;
      tick(); tick();
      check("mc2_valid", 32'(rd_valid), 1);
      rd_req = 1'b0;
      tick();
      check("mc2_clr_pulse", 32'(cnt_clr), 3'b100);
      check("mc2_ovf_in_clr", 32'(ovf), 3'b100);
      tick();
      check("mc2_ovf_clr", 32'(ovf), 3'b000);
      check("mc2_clr_done", 32'(cnt_clr), 0);
      check("mc2_idle", 32'(busy), 0);

      // clr_all beats a simultaneous read; the read follows afterwards
      clr_all = 1'b1; rd_req = 1'b1; rd_sel = 2'd0; rd_clr = 1'b0;
      tick();
      clr_all = 1'b0;
      check("all_clr_pulse", 32'(cnt_clr), 3'b111);
      check("all_clr_busy", 32'(busy), 1);
      check("all_clr_novalid", 32'(rd_valid), 0);
      tick();
      check("all_clr_done", 32'(cnt_clr), 0);
      check("all_clr_idle", 32'(busy), 0);
      check("all_ic0", 32'(ic_count), 0);
      check("all_ma0", 32'(ma_count), 0);
      exp_q.push_back({20'd0, 1'b0});
      tick();
      check("late_snap_busy", 32'(busy), 1);
      tick();
      check("late_valid", 32'(rd_valid), 1);
      rd_req = 1'b0;
      tick();
      check("late_idle", 32'(busy), 0);

      // Invalid select: single rd_err pulse, no state change
      rd_req = 1'b1; rd_sel = 2'd3;
      tick();
      rd_req = 1'b0;
      check("err_pulse", 32'(rd_err), 1);
      check("err_busy", 32'(busy), 0);
      tick();
      check("err_drop", 32'(rd_err), 0);
      check("err_busy2", 32'(busy), 0);

      // Reset in PRESENT aborts the handshake and the pending clear
      inst_evt = 1'b1;
      repeat (3) tick();
      inst_evt = 1'b0;
      mc_load = 1'b1; mc_load_val = 20'hFFFFF;
      tick();
      mc_load = 1'b0; mc_evt = 1'b1;
      tick();
      mc_evt = 1'b0;
      check("pre_rst_ovf", 32'(ovf), 3'b100);
      rd_req = 1'b1; rd_sel = 2'd0; rd_clr = 1'b1; rd_ready = 1'b0;
      tick(); tick();
      check("pre_rst_valid", 32'(rd_valid), 1);
      check("pre_rst_data", 32'(rd_data), 3);
      rd_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("mid_rst_valid", 32'(rd_valid), 0);
      check("mid_rst_data", 32'(rd_data), 0);
      check("mid_rst_ovf", 32'(ovf), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_clr", 32'(cnt_clr), 0);
      rst = 1'b0; rd_ready = 1'b1;
      tick();
      check("post_rst_clr", 32'(cnt_clr), 0);
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_valid", 32'(rd_valid), 0);

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
